// File: rtl/uart_cmd_responder.sv
// Bootloader command responder: parses A5-framed host requests from the UART
// receiver, performs byte reads/writes on a local port and returns a 5A-framed
// response through the transmitter. Define UART_RESP_TIMEOUT_EN for the
// inter-byte timeout.
module uart_cmd_responder #(
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT_CLKS = 2170000
) (
  input  logic              i_Clock,
  input  logic              i_Rst,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic              o_Mem_WE,
  output logic [7:0]        o_Mem_WData,
  output logic              o_Mem_RE,
  input  logic [7:0]        i_Mem_RData,
  output logic              o_Busy,
  output logic              o_Err
);

  localparam logic [7:0] REQ_SYNC  = 8'hA5;
  localparam logic [7:0] RESP_SYNC = 8'h5A;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'h03;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCHK = 8'h01;
  localparam logic [7:0] ST_BADCMD = 8'h02;
  localparam logic [7:0] ST_BADLEN = 8'h03;

  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_PAYLOAD, S_CHK,
    S_TX_SEND, S_TX_WAIT_HI, S_TX_WAIT_LO, S_RD_REQ, S_RD_WAIT, S_RD_CAP
  } state_e;

  typedef enum logic [1:0] {P_SYNC, P_STATUS, P_DATA, P_RCHK} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          addr_h_q, addr_h_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          status_q, status_d;
  logic [7:0]          rchk_q, rchk_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_dv_q, tx_dv_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                in_frame;
  logic                timeout;

  assign in_frame = (state_q == S_CMD)    || (state_q == S_ADDR_H) ||
                    (state_q == S_ADDR_L) || (state_q == S_LEN)    ||
                    (state_q == S_PAYLOAD)|| (state_q == S_CHK);

`ifdef UART_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (in_frame && !i_RX_DV) begin
      to_cnt_d = to_cnt_q + 1'b1;
      timeout  = (to_cnt_d == TO_W'(TIMEOUT_CLKS));
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  // Without the timeout the parameter only keeps the interface uniform.
  assign timeout = (TIMEOUT_CLKS < 0);
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    cmd_d       = cmd_q;
    addr_h_d    = addr_h_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    status_d    = status_q;
    rchk_d      = rchk_q;
    rdata_d     = rdata_q;
    ptr_d       = ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_byte_d   = tx_byte_q;
    tx_dv_d     = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_HUNT: if (i_RX_DV && i_RX_Byte == REQ_SYNC) begin
        chk_d   = '0;
        state_d = S_CMD;
      end
      S_CMD: if (i_RX_DV) begin
        cmd_d   = i_RX_Byte;
        chk_d   = chk_q ^ i_RX_Byte;
        state_d = S_ADDR_H;
      end
      S_ADDR_H: if (i_RX_DV) begin
        addr_h_d = i_RX_Byte;
        chk_d    = chk_q ^ i_RX_Byte;
        state_d  = S_ADDR_L;
      end
      S_ADDR_L: if (i_RX_DV) begin
        ptr_d   = ADDR_W'({addr_h_q, i_RX_Byte});
        chk_d   = chk_q ^ i_RX_Byte;
        state_d = S_LEN;
      end
      S_LEN: if (i_RX_DV) begin
        len_d   = i_RX_Byte;
        cnt_d   = '0;
        chk_d   = chk_q ^ i_RX_Byte;
        // Only a well-formed WRITE carries payload; anything else expects CHK next.
        state_d = (cmd_q == CMD_WRITE && i_RX_Byte != 8'h00) ? S_PAYLOAD : S_CHK;
      end
      S_PAYLOAD: if (i_RX_DV) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q;
        mem_wdata_d = i_RX_Byte;
        ptr_d       = ptr_q + 1'b1;
        chk_d       = chk_q ^ i_RX_Byte;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q + 8'd1 == len_q) state_d = S_CHK;
      end
      S_CHK: if (i_RX_DV) begin
        if (i_RX_Byte != chk_q)
          status_d = ST_BADCHK;
        else if (cmd_q != CMD_WRITE && cmd_q != CMD_READ && cmd_q != CMD_PING)
          status_d = ST_BADCMD;
        else if (len_q == 8'h00)
          status_d = ST_BADLEN;
        else
          status_d = ST_OK;
        rchk_d  = status_d;
        err_d   = (status_d != ST_OK);
        cnt_d   = '0;
        phase_d = P_SYNC;
        state_d = S_TX_SEND;
      end
      S_TX_SEND: if (!i_TX_Active) begin
        tx_dv_d = 1'b1;
        unique case (phase_q)
          P_SYNC:   tx_byte_d = RESP_SYNC;
          P_STATUS: tx_byte_d = status_q;
          P_DATA:   tx_byte_d = rdata_q;
          P_RCHK:   tx_byte_d = rchk_q;
        endcase
        state_d = S_TX_WAIT_HI;
      end
      S_TX_WAIT_HI: if (i_TX_Done) state_d = S_TX_WAIT_LO;
      S_TX_WAIT_LO: if (!i_TX_Done) begin
        unique case (phase_q)
          P_SYNC: begin
            phase_d = P_STATUS;
            state_d = S_TX_SEND;
          end
          P_STATUS: begin
            if (status_q == ST_OK && cmd_q == CMD_READ) begin
              phase_d = P_DATA;
              state_d = S_RD_REQ;
            end else begin
              phase_d = P_RCHK;
              state_d = S_TX_SEND;
            end
          end
          P_DATA: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == len_q) begin
              phase_d = P_RCHK;
              state_d = S_TX_SEND;
            end else begin
              state_d = S_RD_REQ;
            end
          end
          P_RCHK: state_d = S_HUNT;
        endcase
      end
      S_RD_REQ: begin
        mem_re_d   = 1'b1;
        mem_addr_d = ptr_q;
        ptr_d      = ptr_q + 1'b1;
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rdata_d = i_Mem_RData;
        rchk_d  = rchk_q ^ i_Mem_RData;
        state_d = S_TX_SEND;
      end
      default: state_d = S_HUNT;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      state_d = S_HUNT;
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge i_Clock) begin
    // NOTE: synchronous reset is sampled on the clock edge; all state uses <=.
    if (i_Rst) begin
      state_q     <= S_HUNT;
      phase_q     <= P_SYNC;
      cmd_q       <= '0;
      addr_h_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      status_q    <= '0;
      rchk_q      <= '0;
      rdata_q     <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tx_byte_q   <= '0;
      tx_dv_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      addr_h_q    <= addr_h_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      status_q    <= status_d;
      rchk_q      <= rchk_d;
      rdata_q     <= rdata_d;
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tx_byte_q   <= tx_byte_d;
      tx_dv_q     <= tx_dv_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Mem_Addr  = mem_addr_q;
  assign o_Mem_WE    = mem_we_q;
  assign o_Mem_WData = mem_wdata_q;
  assign o_Mem_RE    = mem_re_q;
  assign o_Busy      = busy_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: byte-level transmitter and memory
// models, logged strobes compared against hand-computed frames.
module tb_uart_cmd_responder;

  typedef logic [7:0]  bq_t[$];
  typedef logic [23:0] wq_t[$];
  typedef logic [15:0] aq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bq_t tx_log;
  wq_t wr_log;
  aq_t rd_log;
  int  err_cnt  = 0;
  int  viol_cnt = 0;
  int  tx_ph    = 0;
  int  tx_tm    = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  uart_cmd_responder #(.ADDR_W(16), .TIMEOUT_CLKS(1000)) dut (
    .i_Clock    (clk),
    .i_Rst      (rst),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .o_TX_DV    (tx_dv),
    .o_TX_Byte  (tx_byte),
    .i_TX_Active(tx_active),
    .i_TX_Done  (tx_done),
    .o_Mem_Addr (mem_addr),
    .o_Mem_WE   (mem_we),
    .o_Mem_WData(mem_wdata),
    .o_Mem_RE   (mem_re),
    .i_Mem_RData(mem_rdata),
    .o_Busy     (busy),
    .o_Err      (err)
  );

  // Memory: write on WE, read data valid the cycle after RE.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Transmitter model and strobe monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      tx_ph = 0; tx_tm = 0; tx_active = 1'b0; tx_done = 1'b0;
    end else begin
      if (tx_dv) begin
        if (tx_ph != 0) viol_cnt++;
        tx_log.push_back(tx_byte);
        tx_ph = 1; tx_tm = 0; tx_active = 1'b1;
      end else if (tx_ph == 1) begin
        tx_tm++;
        if (tx_tm == 4) begin
          tx_active = 1'b0; tx_done = 1'b1; tx_ph = 2; tx_tm = 0;
        end
      end else if (tx_ph == 2) begin
        tx_tm++;
        if (tx_tm == 2) begin
          tx_done = 1'b0; tx_ph = 0;
        end
      end
      if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
      if (mem_re) rd_log.push_back(mem_addr);
      if (err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete(); wr_log.delete(); rd_log.delete();
    err_cnt = 0; viol_cnt = 0;
  endtask

  task automatic send(input bq_t b);
    foreach (b[i]) begin
      rx_dv = 1'b1; rx_byte = b[i];
      @(negedge clk);
      rx_dv = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_tx(input string tag, input bq_t exp);
    check({tag, "_tx_n"}, 64'(tx_log.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < tx_log.size()) check($sformatf("%s_tx%0d", tag, i), 64'(tx_log[i]), 64'(exp[i]));
    check({tag, "_hs"}, 64'(viol_cnt), 64'd0);
  endtask

  task automatic check_wr(input string tag, input wq_t exp);
    check({tag, "_wr_n"}, 64'(wr_log.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < wr_log.size()) check($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(exp[i]));
  endtask

  task automatic check_rd(input string tag, input aq_t exp);
    check({tag, "_rd_n"}, 64'(rd_log.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < rd_log.size()) check($sformatf("%s_rd%0d", tag, i), 64'(rd_log[i]), 64'(exp[i]));
  endtask

  function automatic logic [63:0] outs();
    return 64'({tx_dv, tx_byte, mem_addr, mem_we, mem_wdata, mem_re, busy, err});
  endfunction

  task automatic ping(input string tag);
    clear_logs();
    send('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02});
    wait_idle(tag, 500);
    check_tx(tag, '{8'h5A, 8'h00, 8'h00});
    check({tag, "_err"}, 64'(err_cnt), 64'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_held_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", outs(), 64'd0);

    // PING preceded by garbage
    clear_logs();
    send('{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02});
    wait_idle("ping", 500);
    check_tx("ping", '{8'h5A, 8'h00, 8'h00});
    check_wr("ping", '{});
    check_rd("ping", '{});
    check("ping_err", 64'(err_cnt), 64'd0);

    // WRITE two bytes at 1234
    clear_logs();
    send('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h02, 8'hDE, 8'hAD, 8'h56});
    wait_idle("wr", 500);
    check_tx("wr", '{8'h5A, 8'h00, 8'h00});
    check_wr("wr", '{24'h1234DE, 24'h1235AD});
    check("wr_err", 64'(err_cnt), 64'd0);

    // READ them back
    clear_logs();
    send('{8'hA5, 8'h02, 8'h12, 8'h34, 8'h02, 8'h26});
    wait_idle("rd", 800);
    check_tx("rd", '{8'h5A, 8'h00, 8'hDE, 8'hAD, 8'h73});
    check_rd("rd", '{16'h1234, 16'h1235});
    check_wr("rd", '{});

    // Bad checksum
    clear_logs();
    send('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00});
    wait_idle("badchk", 500);
    check_tx("badchk", '{8'h5A, 8'h01, 8'h01});
    check("badchk_err", 64'(err_cnt), 64'd1);

    // Unknown command
    clear_logs();
    send('{8'hA5, 8'h07, 8'h00, 8'h00, 8'h01, 8'h06});
    wait_idle("badcmd", 500);
    check_tx("badcmd", '{8'h5A, 8'h02, 8'h02});
    check("badcmd_err", 64'(err_cnt), 64'd1);

    // WRITE with LEN=0: next byte is the checksum, nothing written
    clear_logs();
    send('{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h11});
    wait_idle("len0", 500);
    check_tx("len0", '{8'h5A, 8'h03, 8'h03});
    check_wr("len0", '{});
    check("len0_err", 64'(err_cnt), 64'd1);

    // Address wrap on write and read
    clear_logs();
    send('{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h30});
    wait_idle("wrap_wr", 500);
    check_tx("wrap_wr", '{8'h5A, 8'h00, 8'h00});
    check_wr("wrap_wr", '{24'hFFFF11, 24'h000022});
    clear_logs();
    send('{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h02, 8'h00});
    wait_idle("wrap_rd", 800);
    check_tx("wrap_rd", '{8'h5A, 8'h00, 8'h11, 8'h22, 8'h33});
    check_rd("wrap_rd", '{16'hFFFF, 16'h0000});

    // Second frame arriving during the response is dropped
    clear_logs();
    send('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02,
           8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02});
    wait_idle("drop", 500);
    repeat (20) @(negedge clk);
    check_tx("drop", '{8'h5A, 8'h00, 8'h00});

`ifdef UART_RESP_TIMEOUT_EN
    clear_logs();
    send('{8'hA5, 8'h03});
    wait_idle("tmo", 1500);
    check_tx("tmo", '{});
    check("tmo_err", 64'(err_cnt), 64'd1);
    ping("tmo_ping");
`endif

    // Reset in the middle of a READ response
    clear_logs();
    send('{8'hA5, 8'h02, 8'h12, 8'h34, 8'h02, 8'h26});
    k = 0;
    while (tx_log.size() < 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("mid_rst_reached", 64'(tx_log.size()), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", outs(), 64'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_rst_tx_n", 64'(tx_log.size()), 64'd2);
    check("mid_rst_rd_n", 64'(rd_log.size()), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    ping("post_rst_ping");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
